alu_cmd_driver: RTL and testbench



---
 rtl/alu_cmd_driver.sv | 170 +++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command initiator for the 7-op ALU: issues one request at a time, shadows the ALU mode,
// detours through DETOUR_OP when a direct mode change would be refused, and returns the result.
module alu_cmd_driver #(
  parameter int         ALU_LAT   = 2,
  parameter logic [2:0] DETOUR_OP = 3'd1
) (
  input  logic        clk_p_i,
  input  logic        reset_p_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [7:0]  req_a_i,
  input  logic [7:0]  req_b_i,
  output logic [2:0]  alu_inst_o,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  input  logic [15:0] alu_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [2:0]  mode_o
);

  localparam int               CNT_W     = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ALU_LAT - 1);
  localparam logic [2:0]       INST_HOLD = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DETOUR = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        op_r, op_s;
  logic [2:0]        alu_inst_r, alu_inst_s;
  logic [7:0]        alu_a_r, alu_a_s;
  logic [7:0]        alu_b_r, alu_b_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [15:0]       rsp_data_r, rsp_data_s;
  logic              rsp_err_r, rsp_err_s;
  logic [2:0]        mode_r, mode_s;
  logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_s;

  // Mode transitions the ALU accepts; re-issuing the current mode is always accepted.
  function automatic logic legal_move(input logic [2:0] cur, input logic [2:0] nxt);
    logic ok_s;
    ok_s = 1'b0;
    if (nxt == INST_HOLD) begin
      ok_s = 1'b0;
    end else if (nxt == cur) begin
      ok_s = 1'b1;
    end else begin
      case (cur)
        3'd0, 3'd1: ok_s = 1'b1;
        3'd2:       ok_s = (nxt == 3'd0) || (nxt == 3'd1) || (nxt == 3'd3) || (nxt == 3'd5);
        3'd3:       ok_s = (nxt == 3'd0) || (nxt == 3'd1) || (nxt == 3'd6);
        3'd4:       ok_s = (nxt == 3'd1) || (nxt == 3'd5);
        3'd5:       ok_s = (nxt == 3'd0) || (nxt == 3'd1) || (nxt == 3'd2);
        3'd6:       ok_s = (nxt == 3'd1) || (nxt == 3'd5);
        default:    ok_s = 1'b0;
      endcase
    end
    return ok_s;
  endfunction

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    alu_inst_s  = INST_HOLD;
    alu_a_s     = alu_a_r;
    alu_b_s     = alu_b_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;
    rsp_err_s   = rsp_err_r;
    mode_s      = mode_r;
    wait_cnt_s  = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_s = req_op_i;
          if (req_op_i == INST_HOLD) begin
            state_s     = ST_RESP;
            rsp_valid_s = 1'b1;
            rsp_data_s  = 16'h0000;
            rsp_err_s   = 1'b1;
          end else begin
            alu_a_s = req_a_i;
            alu_b_s = req_b_i;
            if (legal_move(mode_r, req_op_i)) begin
              state_s    = ST_ISSUE;
              alu_inst_s = req_op_i;
            end else begin
              state_s    = ST_DETOUR;
              alu_inst_s = DETOUR_OP;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DETOUR: begin
        mode_s     = DETOUR_OP;
        state_s    = ST_ISSUE;
        alu_inst_s = op_r;
      end
      ST_ISSUE: begin
        mode_s     = op_r;
        state_s    = ST_WAIT;
        wait_cnt_s = WAIT_INIT;
      end
      ST_WAIT: begin
        if (wait_cnt_r == {CNT_W{1'b0}}) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_data_s  = alu_data_i;
          rsp_err_s   = 1'b0;
        end else begin
          wait_cnt_s = wait_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      state_r     <= ST_IDLE;
      op_r        <= 3'd0;
      alu_inst_r  <= INST_HOLD;
      alu_a_r     <= 8'h00;
      alu_b_r     <= 8'h00;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 16'h0000;
      rsp_err_r   <= 1'b0;
      mode_r      <= 3'd0;
      wait_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      alu_inst_r  <= alu_inst_s;
      alu_a_r     <= alu_a_s;
      alu_b_r     <= alu_b_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
      mode_r      <= mode_s;
      wait_cnt_r  <= wait_cnt_s;
    end
  end

  assign req_ready_o = (state_r == ST_IDLE);
  assign alu_inst_o  = alu_inst_r;
  assign alu_a_o     = alu_a_r;
  assign alu_b_o     = alu_b_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = rsp_data_r;
  assign rsp_err_o   = rsp_err_r;
  assign mode_o      = mode_r;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural two-cycle-latency ALU model.
module tb_alu_cmd_driver;

  logic        clk_p_i = 1'b0;
  logic        reset_p_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = 3'd0;
  logic [7:0]  req_a_i = 8'h00;
  logic [7:0]  req_b_i = 8'h00;
  logic [2:0]  alu_inst_o;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [15:0] alu_data_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        rsp_err_o;
  logic [2:0]  mode_o;

  alu_cmd_driver dut (
    .clk_p_i(clk_p_i), .reset_p_i(reset_p_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .alu_inst_o(alu_inst_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_data_i(alu_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .mode_o(mode_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic [2:0]  mode;
    int          due;
  } sb_t;

  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   det_cnt = 0;
  logic [2:0] exp_mode = 3'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic allowed(input logic [2:0] cur, input logic [2:0] nxt);
    if (nxt == 3'd7) return 1'b0;
    if (nxt == cur) return 1'b1;
    case (cur)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return nxt inside {3'd0, 3'd1, 3'd3, 3'd5};
      3'd3:       return nxt inside {3'd0, 3'd1, 3'd6};
      3'd4:       return nxt inside {3'd1, 3'd5};
      3'd5:       return nxt inside {3'd0, 3'd1, 3'd2};
      3'd6:       return nxt inside {3'd1, 3'd5};
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] aa, bb, d;
    aa = {8'd0, a};
    bb = {8'd0, b};
    d  = bb - aa;
    case (op)
      3'd0:    return aa + bb;
      3'd1:    return d;
      3'd2:    return aa * bb;
      3'd3:    return aa >> 1;
      3'd4:    return ~d;
      3'd5:    return aa ^ bb;
      3'd6:    return (b >= a) ? d : (aa - bb);
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural ALU: refuses illegal mode changes, result two cycles after the command.
  logic [2:0]  alu_mode;
  logic [15:0] alu_st1;
  always @(posedge clk_p_i) begin
    cyc <= cyc + 1;
    if (reset_p_i) begin
      alu_mode   <= 3'd0;
      alu_st1    <= 16'h0000;
      alu_data_i <= 16'h0000;
    end else begin
      if (alu_inst_o == 3'd7) begin
        alu_st1 <= 16'hDEAD;
      end else if (allowed(alu_mode, alu_inst_o)) begin
        alu_mode <= alu_inst_o;
        alu_st1  <= alu_ref(alu_inst_o, alu_a_o, alu_b_o);
      end else begin
        alu_st1 <= 16'hBAD0;
      end
      alu_data_i <= alu_st1;
    end
  end

  // Response monitor: pops the scoreboard on every strobe.
  always @(negedge clk_p_i) begin
    sb_t e;
    if (alu_inst_o == 3'd1) det_cnt <= det_cnt + 1;
    if (rsp_valid_o) begin
      if (sbq.size() == 0) begin
        check_eq("rsp_unexpected", rsp_valid_o, 1'b0);
      end else begin
        e = sbq.pop_front();
        check_eq("rsp_data", rsp_data_o, e.data);
        check_eq("rsp_err", rsp_err_o, e.err);
        check_eq("rsp_mode", mode_o, e.mode);
        check_eq("rsp_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_p_i);
    end
    check_eq("accept_timeout", ok, 1'b1);
  endtask

  task automatic push_expected(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               output logic detour);
    sb_t e;
    detour = 1'b0;
    if (op == 3'd7) begin
      e.data = 16'h0000; e.err = 1'b1; e.mode = exp_mode; e.due = cyc + 1;
    end else begin
      detour   = !allowed(exp_mode, op);
      exp_mode = op;
      e.data = alu_ref(op, a, b); e.err = 1'b0; e.mode = op;
      e.due  = cyc + 4 + (detour ? 1 : 0);
    end
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk_p_i);
    check_eq("rsp_timeout", sbq.size(), 0);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic detour;
    @(negedge clk_p_i);
    req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b;
    wait_ready();
    push_expected(op, a, b, detour);
    @(negedge clk_p_i);
    req_valid_i = 1'b0;
    check_eq("inst_first", alu_inst_o, (op == 3'd7) ? 3'd7 : (detour ? 3'd1 : op));
    if (detour) begin
      @(negedge clk_p_i);
      check_eq("inst_after_detour", alu_inst_o, op);
    end
    drain();
  endtask

  initial begin
    int c_prev;
    logic detour;
    repeat (3) @(negedge clk_p_i);
    reset_p_i = 1'b0;
    check_eq("rst_inst", alu_inst_o, 3'd7);
    check_eq("rst_a", alu_a_o, 8'h00);
    check_eq("rst_b", alu_b_o, 8'h00);
    check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("rst_rsp_data", rsp_data_o, 16'h0000);
    check_eq("rst_rsp_err", rsp_err_o, 1'b0);
    check_eq("rst_mode", mode_o, 3'd0);
    check_eq("rst_ready", req_ready_o, 1'b1);

    send(3'd0, 8'd3, 8'd5);
    send(3'd2, 8'h10, 8'h10);
    send(3'd6, 8'd9, 8'd4);
    send(3'd1, 8'd9, 8'd4);
    send(3'd4, 8'd9, 8'd4);
    send(3'd7, 8'd1, 8'd2);
    check_eq("err_mode_kept", mode_o, 3'd4);

    // Reset during the first WAIT cycle drops the request.
    @(negedge clk_p_i);
    req_valid_i = 1'b1; req_op_i = 3'd5; req_a_i = 8'd3; req_b_i = 8'd6;
    wait_ready();
    @(negedge clk_p_i);
    req_valid_i = 1'b0;
    @(negedge clk_p_i);
    reset_p_i = 1'b1;
    repeat (2) @(negedge clk_p_i);
    reset_p_i = 1'b0;
    exp_mode = 3'd0;
    check_eq("abort_mode", mode_o, 3'd0);
    check_eq("abort_ready", req_ready_o, 1'b1);
    check_eq("abort_inst", alu_inst_o, 3'd7);
    repeat (8) @(negedge clk_p_i);
    send(3'd0, 8'd1, 8'd1);

    // Back-to-back with valid held high.
    det_cnt = 0;
    c_prev = 0;
    @(negedge clk_p_i);
    req_valid_i = 1'b1; req_op_i = 3'd3; req_a_i = 8'hFF; req_b_i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      if (k > 0) check_eq("b2b_interval", cyc - c_prev, 5);
      c_prev = cyc;
      push_expected(3'd3, 8'hFF, 8'h00, detour);
      @(negedge clk_p_i);
    end
    req_valid_i = 1'b0;
    drain();
    check_eq("b2b_no_detour", det_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
